tdp_ram_access_ctrl: RTL and testbench



---
 rtl/tdp_ram_access_ctrl.sv | 128 ++++++++++++
 tb/tb_tdp_ram_access_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdp_ram_access_ctrl.sv
// Two-port request front-end for a true dual-port RAM.
// Optional collision counters: define TDP_COLLISION_STATS_EN.
module tdp_ram_access_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 64,
  parameter int STATS_W = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_rsp_valid,
  output logic [WIDTH-1:0] a_rsp_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_rsp_valid,
  output logic [WIDTH-1:0] b_rsp_data,
`ifdef TDP_COLLISION_STATS_EN
  input  logic             stats_clr,
  output logic [STATS_W-1:0] ww_coll_cnt,
  output logic [STATS_W-1:0] wr_coll_cnt,
`endif
  output logic             ram_we_a,
  output logic             ram_we_b,
  output logic [AW-1:0]    ram_addr_a,
  output logic [AW-1:0]    ram_addr_b,
  output logic [WIDTH-1:0] ram_data_a,
  output logic [WIDTH-1:0] ram_data_b,
  input  logic [WIDTH-1:0] ram_q_a,
  input  logic [WIDTH-1:0] ram_q_b
);

  if (STATS_W < 1) begin : g_bad_stats_w
    $error("STATS_W must be at least 1");
  end

  typedef enum logic {RR_A, RR_B} rr_t;

  rr_t rr, rr_nxt;

  logic coll, ww, wr;
  logic a_acc, b_acc;
  logic a_ff, b_ff;
  logic [WIDTH-1:0] a_fwd, b_fwd;
  logic [WIDTH-1:0] a_hold, b_hold;

  assign coll = a_valid && b_valid
             && (a_addr == b_addr) && (a_we || b_we);
  assign ww   = coll && a_we && b_we;
  assign wr   = coll && (a_we != b_we);

  always_ff @(posedge clk) begin
    if (!rst_n) rr <= RR_A;
    else        rr <= rr_nxt;
  end

  // the rr port wins a write/write; the loser gets the next turn
  always_comb begin
    rr_nxt  = rr;
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (rst_n) begin
      a_ready = !(ww && rr == RR_B);
      b_ready = !(ww && rr == RR_A);
      if (ww) rr_nxt = (rr == RR_A) ? RR_B : RR_A;
    end
  end

  assign a_acc = a_valid && a_ready;
  assign b_acc = b_valid && b_ready;

  assign ram_we_a   = a_acc && a_we;
  assign ram_we_b   = b_acc && b_we;
  assign ram_addr_a = a_addr;
  assign ram_addr_b = b_addr;
  assign ram_data_a = a_wdata;
  assign ram_data_b = b_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_ff        <= 1'b0;
      b_ff        <= 1'b0;
      a_fwd       <= '0;
      b_fwd       <= '0;
      a_hold      <= '0;
      b_hold      <= '0;
    end else begin
      a_rsp_valid <= a_acc && !a_we;
      b_rsp_valid <= b_acc && !b_we;
      a_ff        <= wr && !a_we;
      b_ff        <= wr && !b_we;
      if (wr && !a_we) a_fwd <= b_wdata;
      if (wr && !b_we) b_fwd <= a_wdata;
      a_hold      <= a_rsp_data;
      b_hold      <= b_rsp_data;
    end
  end

  // RAM q lands in the cycle after the read; hold it otherwise
  assign a_rsp_data = !a_rsp_valid ? a_hold
                    : (a_ff ? a_fwd : ram_q_a);
  assign b_rsp_data = !b_rsp_valid ? b_hold
                    : (b_ff ? b_fwd : ram_q_b);

`ifdef TDP_COLLISION_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) begin
      ww_coll_cnt <= '0;
      wr_coll_cnt <= '0;
    end else begin
      if (ww && ww_coll_cnt != '1)
        ww_coll_cnt <= ww_coll_cnt + 1'b1;
      if (wr && wr_coll_cnt != '1)
        wr_coll_cnt <= wr_coll_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tdp_ram_access_ctrl.sv
// Bench for tdp_ram_access_ctrl: RAM model, reference model,
// directed scenarios and randomized traffic.
module tb_tdp_ram_access_ctrl;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 64;
  localparam int STATS_W = 16;
  localparam int AW      = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_valid = 1'b0, a_we = 1'b0;
  logic b_valid = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [WIDTH-1:0] a_wdata = '0, b_wdata = '0;
  logic a_ready, b_ready, a_rsp_valid, b_rsp_valid;
  logic [WIDTH-1:0] a_rsp_data, b_rsp_data;
  logic ram_we_a, ram_we_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [WIDTH-1:0] ram_data_a, ram_data_b;
  logic [WIDTH-1:0] ram_q_a = '0, ram_q_b = '0;
`ifdef TDP_COLLISION_STATS_EN
  logic stats_clr = 1'b0;
  logic [STATS_W-1:0] ww_coll_cnt, wr_coll_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tdp_ram_access_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .STATS_W(STATS_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we),
    .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we),
    .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
`ifdef TDP_COLLISION_STATS_EN
    .stats_clr(stats_clr),
    .ww_coll_cnt(ww_coll_cnt), .wr_coll_cnt(wr_coll_cnt),
`endif
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
  );

  // true dual-port RAM with registered outputs
  logic [WIDTH-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (ram_we_a) ram[ram_addr_a] <= ram_data_a;
    if (ram_we_b) ram[ram_addr_b] <= ram_data_b;
    ram_q_a <= ram[ram_addr_a];
    ram_q_b <= ram[ram_addr_b];
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // reference model: memory image with write-first collisions
  logic [WIDTH-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  bit m_turn_b = 1'b0;
  bit m_av = 1'b0, m_bv = 1'b0;
  logic [WIDTH-1:0] m_ad = '0, m_bd = '0;
  logic [STATS_W-1:0] m_wwc = '0, m_wrc = '0;

  always @(negedge clk) begin
    bit same, isww, iswr, er_a, er_b, acc_a, acc_b, clr;
    same = a_valid && b_valid && (a_addr == b_addr);
    isww = same && a_we && b_we;
    iswr = same && (a_we != b_we);
    er_a = rst_n && !(isww && m_turn_b);
    er_b = rst_n && !(isww && !m_turn_b);
    acc_a = a_valid && er_a;
    acc_b = b_valid && er_b;
    check("a_ready", 32'(a_ready), 32'(er_a));
    check("b_ready", 32'(b_ready), 32'(er_b));
    check("ram_we_a", 32'(ram_we_a), 32'(acc_a && a_we));
    check("ram_we_b", 32'(ram_we_b), 32'(acc_b && b_we));
    check("ram_addr_a", 32'(ram_addr_a), 32'(a_addr));
    check("ram_addr_b", 32'(ram_addr_b), 32'(b_addr));
    check("ram_data_a", 32'(ram_data_a), 32'(a_wdata));
    check("ram_data_b", 32'(ram_data_b), 32'(b_wdata));
    check("a_rsp_valid", 32'(a_rsp_valid), 32'(m_av));
    check("b_rsp_valid", 32'(b_rsp_valid), 32'(m_bv));
    check("a_rsp_data", 32'(a_rsp_data), 32'(m_ad));
    check("b_rsp_data", 32'(b_rsp_data), 32'(m_bd));
`ifdef TDP_COLLISION_STATS_EN
    check("ww_coll_cnt", 32'(ww_coll_cnt), 32'(m_wwc));
    check("wr_coll_cnt", 32'(wr_coll_cnt), 32'(m_wrc));
    clr = !rst_n || stats_clr;
`else
    clr = !rst_n;
`endif
    if (clr) begin
      m_wwc = '0;
      m_wrc = '0;
    end else begin
      if (isww && m_wwc != '1) m_wwc = m_wwc + 1'b1;
      if (iswr && m_wrc != '1) m_wrc = m_wrc + 1'b1;
    end
    if (!rst_n) begin
      m_av = 0; m_bv = 0;
      m_ad = '0; m_bd = '0;
      m_turn_b = 0;
    end else begin
      m_av = acc_a && !a_we;
      m_bv = acc_b && !b_we;
      if (m_av)
        m_ad = (acc_b && b_we && b_addr == a_addr) ? b_wdata : mem[a_addr];
      if (m_bv)
        m_bd = (acc_a && a_we && a_addr == b_addr) ? a_wdata : mem[b_addr];
      if (acc_a && a_we) mem[a_addr] = a_wdata;
      if (acc_b && b_we) mem[b_addr] = b_wdata;
      if (isww) m_turn_b = !m_turn_b;
    end
  end

  // apply one cycle of inputs, return at the following negedge
  task automatic drive(input bit rst,
                       input bit av, input bit awe,
                       input int aa, input int ad,
                       input bit bv, input bit bwe,
                       input int ba, input int bd);
    @(posedge clk);
    #1;
    rst_n = rst;
    a_valid = av; a_we = awe;
    a_addr = AW'(aa); a_wdata = WIDTH'(ad);
    b_valid = bv; b_we = bwe;
    b_addr = AW'(ba); b_wdata = WIDTH'(bd);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset with both ports requesting
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 1, 'h33, 1, 1, 1, 'h44);
      check("rst a_ready", 32'(a_ready), 0);
      check("rst b_ready", 32'(b_ready), 0);
      check("rst ram_we_a", 32'(ram_we_a), 0);
      check("rst ram_we_b", 32'(ram_we_b), 0);
      check("rst a_rsp_valid", 32'(a_rsp_valid), 0);
      check("rst b_rsp_valid", 32'(b_rsp_valid), 0);
    end

    // independent ports
    drive(1, 1, 1, 3, 'h5A, 1, 1, 7, 'hC3);
    check("ind ram_we_a", 32'(ram_we_a), 1);
    drive(1, 1, 0, 7, 0, 1, 0, 3, 0);
    idle();
    check("ind a_rsp_valid", 32'(a_rsp_valid), 1);
    check("ind a_rsp_data", 32'(a_rsp_data), 'hC3);
    check("ind b_rsp_valid", 32'(b_rsp_valid), 1);
    check("ind b_rsp_data", 32'(b_rsp_data), 'h5A);
    idle();
    check("ind a_rsp_drop", 32'(a_rsp_valid), 0);
    check("ind a_rsp_hold", 32'(a_rsp_data), 'hC3);

    // write/write collision, A wins first
    drive(1, 1, 1, 10, 'h11, 1, 1, 10, 'h22);
    check("ww0 a_ready", 32'(a_ready), 1);
    check("ww0 b_ready", 32'(b_ready), 0);
    drive(1, 0, 0, 10, 0, 1, 1, 10, 'h22);
    check("ww1 b_ready", 32'(b_ready), 1);
`ifdef TDP_COLLISION_STATS_EN
    check("ww cnt", 32'(ww_coll_cnt), 1);
`endif
    drive(1, 1, 0, 10, 0, 0, 0, 0, 0);
    idle();
    check("ww read", 32'(a_rsp_data), 'h22);

    // alternation from a fresh pointer
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 20, 'hAA, 1, 1, 20, 'hBB);
      check("alt a_ready", 32'(a_ready), 32'(i % 2 == 0));
      check("alt b_ready", 32'(b_ready), 32'(i % 2 == 1));
    end

    // write/read forward on a never-written word
    drive(1, 1, 1, 5, 'h9F, 1, 0, 5, 0);
    check("fw a_ready", 32'(a_ready), 1);
    check("fw b_ready", 32'(b_ready), 1);
    idle();
    check("fw b_rsp_valid", 32'(b_rsp_valid), 1);
    check("fw b_rsp_data", 32'(b_rsp_data), 'h9F);
`ifdef TDP_COLLISION_STATS_EN
    check("wr cnt", 32'(wr_coll_cnt), 1);
`endif

    // read issued into a reset edge is dropped
    drive(0, 1, 0, 3, 0, 0, 0, 0, 0);
    idle();
    check("midrst a_rsp_valid", 32'(a_rsp_valid), 0);
`ifdef TDP_COLLISION_STATS_EN
    check("midrst ww cnt", 32'(ww_coll_cnt), 0);
    check("midrst wr cnt", 32'(wr_coll_cnt), 0);
`endif

    // randomized traffic; a stalled request is held
    for (int n = 0; n < 3000; n++) begin
      bit rs, av, awe, bv, bwe;
      int aa, ad, ba, bd;
      rs = ($urandom_range(0, 63) != 0);
      if (a_valid && !a_ready && rst_n) begin
        av = 1; awe = a_we; aa = int'(a_addr); ad = int'(a_wdata);
      end else begin
        av = ($urandom_range(0, 3) != 0); awe = 1'($urandom);
        aa = $urandom_range(0, 3); ad = $urandom_range(0, 255);
      end
      if (b_valid && !b_ready && rst_n) begin
        bv = 1; bwe = b_we; ba = int'(b_addr); bd = int'(b_wdata);
      end else begin
        bv = ($urandom_range(0, 3) != 0); bwe = 1'($urandom);
        ba = $urandom_range(0, 3); bd = $urandom_range(0, 255);
      end
      drive(rs, av, awe, aa, ad, bv, bwe, ba, bd);
    end

`ifdef TDP_COLLISION_STATS_EN
    // saturation and clear
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 65540; n++)
      drive(1, 1, 1, 0, 'h01, 1, 1, 0, 'h02);
    check("ww sat", 32'(ww_coll_cnt), 'hFFFF);
    @(posedge clk);
    #1;
    stats_clr = 1'b1;
    @(negedge clk);
    drive(1, 1, 1, 0, 'h01, 1, 1, 0, 'h02);
    stats_clr = 1'b0;
    check("ww clr", 32'(ww_coll_cnt), 0);
`endif

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
